// File: rtl/lsu_store_queue_if.sv
// ---------------------------------------------------------------------------
// lsu_store_queue_if
// Drain bus between the store queue and the scratchpad write port.
//
// Signals:
//   req    store queue -> memory : drain request, payload valid while high
//   addr   store queue -> memory : drain address (XLEN)
//   wdata  store queue -> memory : drain data, lane-aligned (XLEN)
//   be     store queue -> memory : drain byte enables (XLEN/8)
//   ready  memory -> store queue : request accepted this cycle
//   error  memory -> store queue : write failed, valid together with ready
//
// Modports:
//   master : the store queue side
//   slave  : the memory side
// ---------------------------------------------------------------------------
interface lsu_store_queue_if #(
    parameter int XLEN = 32
) ();
    localparam int NB = XLEN / 8;

    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [NB-1:0]   be;
    logic            ready;
    logic            error;

    modport master (
        output req,
        output addr,
        output wdata,
        output be,
        input  ready,
        input  error
    );

    modport slave (
        input  req,
        input  addr,
        input  wdata,
        input  be,
        output ready,
        output error
    );
endinterface

// File: rtl/lsu_store_queue.sv
// ---------------------------------------------------------------------------
// lsu_store_queue
// Program-ordered store queue. Stores are allocated at dispatch, committed in
// order by the ROB, dropped on flush while still uncommitted, and drained to
// the scratchpad one request at a time. Loads search the queue combinationally
// and receive age-correct, byte-merged forwarded data.
//
// Optional build macro:
//   LSU_SQ_COALESCE_EN - when defined, two committed entries at the head that
//                        share a word address are drained as one request.
//                        When undefined, every entry gets its own request.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   alloc_valid/ready          allocation handshake (ready = not full)
//   alloc_rob_idx/addr/data/be store being allocated
//   sq_tail_ptr                tail pointer, snapshotted by loads at dispatch
//   commit_en, commit_rob_idx  in-order commit from the ROB
//   commit_err                 one-cycle pulse on a bad or empty commit
//   flush                      drop every uncommitted entry
//   fwd_addr/be/sq_tail        load lookup request and its tail snapshot
//   fwd_hit/partial/data       forwarding result
//   mem                        drain bus (lsu_store_queue_if.master)
//   drain_err                  one-cycle pulse when a drain reports an error
//   sq_count                   number of occupied entries
// ---------------------------------------------------------------------------
module lsu_store_queue #(
    parameter  int SQ_DEPTH  = 8,
    parameter  int XLEN      = 32,
    parameter  int ROB_IDX_W = 6,
    localparam int IDX_W     = $clog2(SQ_DEPTH),
    localparam int PTR_W     = IDX_W + 1,
    localparam int NB        = XLEN / 8,
    localparam int WOFF      = $clog2(NB)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [ROB_IDX_W-1:0] alloc_rob_idx,
    input  logic [XLEN-1:0]      alloc_addr,
    input  logic [XLEN-1:0]      alloc_data,
    input  logic [NB-1:0]        alloc_be,
    output logic [PTR_W-1:0]     sq_tail_ptr,

    input  logic                 commit_en,
    input  logic [ROB_IDX_W-1:0] commit_rob_idx,
    output logic                 commit_err,

    input  logic                 flush,

    input  logic [XLEN-1:0]      fwd_addr,
    input  logic [NB-1:0]        fwd_be,
    input  logic [PTR_W-1:0]     fwd_sq_tail,
    output logic                 fwd_hit,
    output logic                 fwd_partial,
    output logic [XLEN-1:0]      fwd_data,

    lsu_store_queue_if.master    mem,
    output logic                 drain_err,

    output logic [PTR_W-1:0]     sq_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } drain_state_t;

    // Entry storage. Occupancy is defined purely by the pointers, so the
    // payload arrays need no reset.
    logic [XLEN-1:0]      addr_q [SQ_DEPTH];
    logic [XLEN-1:0]      data_q [SQ_DEPTH];
    logic [NB-1:0]        be_q   [SQ_DEPTH];
    logic [ROB_IDX_W-1:0] rob_q  [SQ_DEPTH];

    logic [PTR_W-1:0] head_q, cmt_q, tail_q;
    logic [PTR_W-1:0] head_d, cmt_d, tail_d;
    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;

    logic alloc_fire;
    logic commit_ok;
    logic commit_err_q;
    logic drain_err_q;

    drain_state_t state_q, state_d;
    logic         load_payload;
    logic         drain_fire;

    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic [NB-1:0]   mem_be_q;
    logic            pair_q;

    logic [XLEN-1:0] pay_addr, pay_data;
    logic [NB-1:0]   pay_be;
    logic            pay_pair;

    logic [PTR_W-1:0] fwd_span, fwd_limit;
    logic [IDX_W-1:0] fwd_slot;
    logic [NB-1:0]    fwd_cov;

    // The low address bits of a load only select lanes through fwd_be.
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign sq_count    = tail_q - head_q;
    assign alloc_ready = (sq_count != PTR_W'(SQ_DEPTH));
    assign sq_tail_ptr = tail_q;
    assign commit_err  = commit_err_q;
    assign drain_err   = drain_err_q;

    // A flush in the same cycle wins over allocation.
    assign alloc_fire = alloc_valid && alloc_ready && !flush;

    assign commit_ok = commit_en && (cmt_q != tail_q) &&
                       (rob_q[cmt_idx] == commit_rob_idx);

    // Pointer next-state. Flush rewinds the tail to the commit pointer as it
    // stands after this cycle's commit, so a same-cycle commit survives.
    always_comb begin
        cmt_d  = commit_ok ? cmt_q + PTR_W'(1) : cmt_q;
        tail_d = tail_q;
        if (flush) begin
            tail_d = cmt_d;
        end else if (alloc_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        head_d = head_q;
        if (drain_fire) begin
            head_d = head_q + (pair_q ? PTR_W'(2) : PTR_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
            commit_err_q <= 1'b0;
            drain_err_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            cmt_q        <= cmt_d;
            tail_q       <= tail_d;
            commit_err_q <= commit_en && !commit_ok;
            drain_err_q  <= drain_fire && mem.error;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_q[tail_idx] <= alloc_addr;
            data_q[tail_idx] <= alloc_data;
            be_q[tail_idx]   <= alloc_be;
            rob_q[tail_idx]  <= alloc_rob_idx;
        end
    end

    // Drain payload selection. With coalescing, the younger entry's bytes
    // override the older one in overlapping lanes.
`ifdef LSU_SQ_COALESCE_EN
    logic [PTR_W-1:0] head_p1;
    logic [IDX_W-1:0] head_p1_idx;
    logic             pair_ok;

    assign head_p1     = head_q + PTR_W'(1);
    assign head_p1_idx = head_p1[IDX_W-1:0];
    assign pair_ok     = ((cmt_q - head_q) >= PTR_W'(2)) &&
                         (addr_q[head_idx][XLEN-1:WOFF] ==
                          addr_q[head_p1_idx][XLEN-1:WOFF]);
`endif

    always_comb begin
        pay_addr = addr_q[head_idx];
        pay_data = data_q[head_idx];
        pay_be   = be_q[head_idx];
        pay_pair = 1'b0;
`ifdef LSU_SQ_COALESCE_EN
        if (pair_ok) begin
            pay_pair = 1'b1;
            pay_be   = be_q[head_idx] | be_q[head_p1_idx];
            for (int b = 0; b < NB; b++) begin
                if (be_q[head_p1_idx][b]) begin
                    pay_data[8*b +: 8] = data_q[head_p1_idx][8*b +: 8];
                end
            end
        end
`endif
    end

    // Drain FSM: IDLE latches the oldest committed store, REQ holds it until
    // memory accepts. Each accepted request passes through IDLE again.
    always_comb begin
        state_d      = state_q;
        load_payload = 1'b0;
        drain_fire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_q != cmt_q) begin
                    load_payload = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.ready) begin
                    drain_fire = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            pair_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_payload) begin
                mem_addr_q  <= pay_addr;
                mem_wdata_q <= pay_data;
                mem_be_q    <= pay_be;
                pair_q      <= pay_pair;
            end
        end
    end

    // mem.req decodes the state register directly so reset drops it at once.
    assign mem.req   = (state_q == S_REQ);
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign mem.be    = mem_be_q;

    // Store-to-load forwarding. Candidates run from head up to the load's
    // tail snapshot. A snapshot outside the occupied range belongs to a load
    // whose older stores are all gone, so it sees no candidates. Entries are
    // walked oldest to youngest so the youngest writer of each lane wins.
    always_comb begin
        fwd_span  = fwd_sq_tail - head_q;
        fwd_limit = (fwd_span <= sq_count) ? fwd_span : '0;
        fwd_slot  = head_idx;
        fwd_cov   = '0;
        fwd_data  = '0;
        for (int j = 0; j < SQ_DEPTH; j++) begin
            fwd_slot = head_idx + IDX_W'(j);
            if ((PTR_W'(j) < fwd_limit) &&
                (addr_q[fwd_slot][XLEN-1:WOFF] == fwd_addr[XLEN-1:WOFF])) begin
                for (int b = 0; b < NB; b++) begin
                    if (fwd_be[b] && be_q[fwd_slot][b]) begin
                        fwd_cov[b]         = 1'b1;
                        fwd_data[8*b +: 8] = data_q[fwd_slot][8*b +: 8];
                    end
                end
            end
        end
        fwd_hit     = (fwd_be != '0) && (fwd_cov == fwd_be);
        fwd_partial = (fwd_cov != '0) && (fwd_cov != fwd_be);
    end

endmodule
